// File: rtl/uart_rx_pkg.sv
// Shared constants and helpers for the UART receiver slice.
package uart_rx_pkg;

  // Default frame timing. Used as parameter defaults by rx_timer and the shift register.
  localparam int UART_CLKS_PER_BIT = 10;
  localparam int UART_FIRST_PERIOD = 12;
  localparam int UART_DATA_BITS    = 8;

  // States of the bit timer. These are decoded from enable_timer and bit_index,
  // so no separate state register exists.
  typedef enum logic [1:0] {
    TMR_IDLE     = 2'd0,
    TMR_COUNTING = 2'd1,
    TMR_DONE     = 2'd2
  } timer_state_e;

  // Width of bit_index. It must hold 0 .. data_bits+1 (all data bits plus the stop strobe).
  function automatic int bit_index_width(input int data_bits);
    return $clog2(data_bits + 2);
  endfunction

  // Width of the cycle counter. It must hold 0 .. max(first_period, clks_per_bit)-1.
  function automatic int clk_cnt_width(input int first_period, input int clks_per_bit);
    int max_period;
    max_period = (first_period > clks_per_bit) ? first_period : clks_per_bit;
    return (max_period < 2) ? 1 : $clog2(max_period);
  endfunction

endpackage

// File: rtl/flex_counter.sv
// Up-counter with a run-time rollover value. It wraps to 0 after reaching rollover_val.
// The synchronous clear takes priority over counting.
module flex_counter
  import uart_rx_pkg::*;
#(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] r_count;

  // Count register: async reset, then clear, then wrap-or-increment.
  // NOTE: state is updated with non-blocking assignments, so every flop in the
  // design samples the pre-edge values and there is no ordering race between blocks.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (count_enable) begin
      r_count <= (r_count == rollover_val) ? '0 : r_count + NUM_CNT_BITS'(1);
    end
  end

  assign count_out     = r_count;
  assign rollover_flag = (r_count == rollover_val);

endmodule

// File: rtl/rx_timer.sv
// Bit-timing stage of the UART receiver. While enable_timer is high it issues one
// shift_strobe in the middle of each data bit and the stop bit. It then holds
// packet_done until enable_timer drops.
module rx_timer
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int FIRST_PERIOD = UART_FIRST_PERIOD,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                                  clk,
  input  logic                                  n_rst,
  input  logic                                  enable_timer,
  output logic                                  shift_strobe,
  output logic                                  packet_done,
  output logic [bit_index_width(DATA_BITS)-1:0] bit_index
);

  localparam int IDX_W = bit_index_width(DATA_BITS);
  localparam int CNT_W = clk_cnt_width(FIRST_PERIOD, CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] FIRST_LAST = CNT_W'(FIRST_PERIOD - 1);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_STOP   = IDX_W'(DATA_BITS);
  localparam logic [IDX_W-1:0] IDX_DONE   = IDX_W'(DATA_BITS + 1);

  logic [CNT_W-1:0] w_clk_cnt;
  logic [CNT_W-1:0] w_period_last;
  logic             w_cnt_roll;
  logic [IDX_W-1:0] w_bit_idx;
  logic             w_idx_done;
  logic             w_clear;
  timer_state_e     w_state;
  logic             w_strobe_next;
  logic             w_done_next;
  logic             r_shift_strobe;
  logic             r_packet_done;

  // The first period runs from the frame start to the middle of data bit 0.
  // Every later period is one bit time long.
  assign w_period_last = (w_bit_idx == '0) ? FIRST_LAST : BIT_LAST;
  assign w_clear       = ~enable_timer;

  // Decode the implicit state: idle when disabled, done after the stop strobe.
  always_comb begin
    w_state = TMR_IDLE;
    if (enable_timer) begin
      w_state = w_idx_done ? TMR_DONE : TMR_COUNTING;
    end
  end

  // Cycle counter within the current bit period. It is frozen once the frame is done.
  flex_counter #(
    .NUM_CNT_BITS (CNT_W)
  ) u_clk_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (w_clear),
    .count_enable  (w_state == TMR_COUNTING),
    .rollover_val  (w_period_last),
    .count_out     (w_clk_cnt),
    .rollover_flag (w_cnt_roll)
  );

  // Strobe counter. Its rollover point is the DONE index, and the counter is
  // never enabled there, so the rollover flag doubles as the DONE decode.
  flex_counter #(
    .NUM_CNT_BITS (IDX_W)
  ) u_bit_idx (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (w_clear),
    .count_enable  ((w_state == TMR_COUNTING) && w_cnt_roll),
    .rollover_val  (IDX_DONE),
    .count_out     (w_bit_idx),
    .rollover_flag (w_idx_done)
  );

  // Next values of the registered outputs.
  always_comb begin
    w_strobe_next = 1'b0;
    w_done_next   = 1'b0;
    case (w_state)
      TMR_COUNTING: begin
        w_strobe_next = w_cnt_roll;
        w_done_next   = w_cnt_roll && (w_bit_idx == IDX_STOP);
      end
      TMR_DONE: w_done_next = 1'b1;
      default: begin
        w_strobe_next = 1'b0;
        w_done_next   = 1'b0;
      end
    endcase
  end

  // Output registers, so enable_timer has no combinational path to any output.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_shift_strobe <= 1'b0;
      r_packet_done  <= 1'b0;
    end else begin
      r_shift_strobe <= w_strobe_next;
      r_packet_done  <= w_done_next;
    end
  end

  assign shift_strobe = r_shift_strobe;
  assign packet_done  = r_packet_done;
  assign bit_index    = w_bit_idx;

endmodule

// File: tb/tb_rx_timer.sv
// Directed bench for rx_timer: default timing, re-enable, abort, async reset, small parameters.
module tb_rx_timer;
  import uart_rx_pkg::*;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       en_a = 1'b0;
  logic       en_b = 1'b0;
  logic       strobe_a, done_a;
  logic [3:0] idx_a;
  logic       strobe_b, done_b;
  logic [2:0] idx_b;

  int vectors = 0;
  int miscompares = 0;

  // Hand-derived strobe edges (edge 1 = first edge with enable sampled high).
  int def_edges   [9] = '{12, 22, 32, 42, 52, 62, 72, 82, 92};
  int small_edges [6] = '{6, 10, 14, 18, 22, 26};

  always #5 clk = ~clk;

  rx_timer dut_a (
    .clk          (clk),
    .n_rst        (n_rst),
    .enable_timer (en_a),
    .shift_strobe (strobe_a),
    .packet_done  (done_a),
    .bit_index    (idx_a)
  );

  rx_timer #(
    .CLKS_PER_BIT (4),
    .FIRST_PERIOD (6),
    .DATA_BITS    (5)
  ) dut_b (
    .clk          (clk),
    .n_rst        (n_rst),
    .enable_timer (en_b),
    .shift_strobe (strobe_b),
    .packet_done  (done_b),
    .bit_index    (idx_b)
  );

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int def_count(input int e);
    int n = 0;
    foreach (def_edges[i]) if (def_edges[i] <= e) n++;
    return n;
  endfunction

  function automatic bit def_hit(input int e);
    foreach (def_edges[i]) if (def_edges[i] == e) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int small_count(input int e);
    int n = 0;
    foreach (small_edges[i]) if (small_edges[i] <= e) n++;
    return n;
  endfunction

  function automatic bit small_hit(input int e);
    foreach (small_edges[i]) if (small_edges[i] == e) return 1'b1;
    return 1'b0;
  endfunction

  task automatic test_reset();
    en_a = 1'b1;
    en_b = 1'b1;
    n_rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      vectors++;
      if ({strobe_a, done_a, idx_a} !== 6'b0 || {strobe_b, done_b, idx_b} !== 5'b0) begin
        miscompares++;
        $display("FAIL reset cyc%0d: a strobe=%b done=%b idx=%0d b strobe=%b done=%b idx=%0d, want all 0",
                 c, strobe_a, done_a, idx_a, strobe_b, done_b, idx_b);
      end
    end
    en_a = 1'b0;
    en_b = 1'b0;
    n_rst = 1'b1;
    tick();
  endtask

  // Default parameters, enable held for 100 edges.
  task automatic test_defaults();
    en_a = 1'b1;
    for (int e = 1; e <= 100; e++) begin
      tick();
      vectors++;
      if (strobe_a !== def_hit(e) || int'(idx_a) != def_count(e) || done_a !== (e >= 92)) begin
        miscompares++;
        $display("FAIL defaults edge%0d: strobe=%b done=%b idx=%0d, want strobe=%b done=%b idx=%0d",
                 e, strobe_a, done_a, idx_a, def_hit(e), (e >= 92), def_count(e));
      end
    end
  endtask

  // Single-cycle drop after DONE, then a fresh frame.
  task automatic test_reenable();
    en_a = 1'b0;
    tick();
    vectors++;
    if ({strobe_a, done_a, idx_a} !== 6'b0) begin
      miscompares++;
      $display("FAIL reenable_clear: strobe=%b done=%b idx=%0d, want 0 0 0", strobe_a, done_a, idx_a);
    end
    en_a = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      vectors++;
      if (strobe_a !== (e == 12) || int'(idx_a) != ((e == 12) ? 1 : 0) || done_a !== 1'b0) begin
        miscompares++;
        $display("FAIL reenable edge%0d: strobe=%b done=%b idx=%0d, want strobe=%b done=0 idx=%0d",
                 e, strobe_a, done_a, idx_a, (e == 12), (e == 12) ? 1 : 0);
      end
    end
    en_a = 1'b0;
    tick();
  endtask

  // Abort after edge 40: strobes at 12, 22, 32 only, then a full clear.
  task automatic test_abort();
    en_a = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      tick();
      vectors++;
      if (strobe_a !== def_hit(e) || int'(idx_a) != def_count(e) || done_a !== 1'b0) begin
        miscompares++;
        $display("FAIL abort edge%0d: strobe=%b done=%b idx=%0d, want strobe=%b done=0 idx=%0d",
                 e, strobe_a, done_a, idx_a, def_hit(e), def_count(e));
      end
    end
    en_a = 1'b0;
    tick();
    vectors++;
    if ({strobe_a, done_a, idx_a} !== 6'b0) begin
      miscompares++;
      $display("FAIL abort edge41: strobe=%b done=%b idx=%0d, want 0 0 0", strobe_a, done_a, idx_a);
    end
  endtask

  // Async reset between edges 50 and 51 with enable held high.
  task automatic test_async_reset();
    en_a = 1'b1;
    for (int e = 1; e <= 50; e++) begin
      tick();
      vectors++;
      if (strobe_a !== def_hit(e) || int'(idx_a) != def_count(e)) begin
        miscompares++;
        $display("FAIL prereset edge%0d: strobe=%b idx=%0d, want strobe=%b idx=%0d",
                 e, strobe_a, idx_a, def_hit(e), def_count(e));
      end
    end
    #2 n_rst = 1'b0;
    #1;
    vectors++;
    if ({strobe_a, done_a, idx_a} !== 6'b0) begin
      miscompares++;
      $display("FAIL async_reset: strobe=%b done=%b idx=%0d, want 0 0 0", strobe_a, done_a, idx_a);
    end
    #1 n_rst = 1'b1;
    for (int e = 1; e <= 13; e++) begin
      tick();
      vectors++;
      if (strobe_a !== (e == 12) || int'(idx_a) != ((e >= 12) ? 1 : 0) || done_a !== 1'b0) begin
        miscompares++;
        $display("FAIL postreset edge%0d: strobe=%b done=%b idx=%0d, want strobe=%b done=0 idx=%0d",
                 e, strobe_a, done_a, idx_a, (e == 12), (e >= 12) ? 1 : 0);
      end
    end
    en_a = 1'b0;
    tick();
  endtask

  // CLKS_PER_BIT=4, FIRST_PERIOD=6, DATA_BITS=5.
  task automatic test_small_params();
    en_b = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      tick();
      vectors++;
      if (strobe_b !== small_hit(e) || int'(idx_b) != small_count(e) || done_b !== (e >= 26)) begin
        miscompares++;
        $display("FAIL small edge%0d: strobe=%b done=%b idx=%0d, want strobe=%b done=%b idx=%0d",
                 e, strobe_b, done_b, idx_b, small_hit(e), (e >= 26), small_count(e));
      end
    end
    en_b = 1'b0;
    tick();
    vectors++;
    if ({strobe_b, done_b, idx_b} !== 5'b0) begin
      miscompares++;
      $display("FAIL small_clear: strobe=%b done=%b idx=%0d, want 0 0 0", strobe_b, done_b, idx_b);
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_reenable();
    test_abort();
    test_async_reset();
    test_small_params();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rx_timer.md
Name: rx_timer

Overview:
Bit-timing stage of the UART receiver, sitting beside the receiver control unit. Runs while the control unit drives enable_timer. Generates one shift_strobe per bit period, aligned to the middle of each data bit and the stop bit, which the shift register and stop-bit checker consume. Raises packet_done after the stop-bit strobe so the control unit can leave its timing state.

Parameters:
CLKS_PER_BIT, 10, clk cycles per serial bit; must be >= 2
FIRST_PERIOD, 12, enabled cycles from timer start to the first (data bit 0) strobe; must be >= 1
DATA_BITS, 8, data bits per frame; the frame is timed as DATA_BITS+1 strobes (data bits plus stop)

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
enable_timer  input  1  level from the control unit; high = timing a frame, low = synchronous clear
shift_strobe  output  1  one-cycle pulse; sample or shift serial input this cycle
packet_done  output  1  level; frame fully timed (stop bit sampled)
bit_index  output  $clog2(DATA_BITS+2)  number of strobes issued in the current frame

Behaviour:
- Reset is n_rst, asynchronous, active-low; the clock is clk.
- Reset values: shift_strobe=0, packet_done=0, bit_index=0, internal clk_cnt=0.
- All outputs are registered. There is no combinational path from enable_timer to any output.
- Internal clk_cnt is wide enough for max(FIRST_PERIOD, CLKS_PER_BIT).
- Current period = FIRST_PERIOD when bit_index==0, otherwise CLKS_PER_BIT.
- Per rising edge, evaluated in priority order:
  1. enable_timer==0: clk_cnt<=0, bit_index<=0, shift_strobe<=0, packet_done<=0.
  2. enable_timer==1 and bit_index==DATA_BITS+1 (DONE): hold all counters, shift_strobe<=0, packet_done<=1.
  3. enable_timer==1 and clk_cnt==period-1: clk_cnt<=0, bit_index<=bit_index+1, shift_strobe<=1. packet_done<=1 only if bit_index+1==DATA_BITS+1.
  4. Otherwise: clk_cnt<=clk_cnt+1, shift_strobe<=0.
- Timing, counting the first edge with enable_timer sampled high as edge 1:
  - strobes occur at edges FIRST_PERIOD + k*CLKS_PER_BIT, for k=0..DATA_BITS;
  - packet_done rises on the same edge as the last (stop-bit) strobe;
  - with defaults, strobes fall at edges 12, 22, ..., 92.
- packet_done stays high while enable_timer stays high. It clears on the first edge where enable_timer is sampled low.
- No strobes are issued after DONE, however long enable_timer stays high.
- Abort: enable_timer falling mid-frame clears everything on the next edge. A later rise starts a fresh frame using FIRST_PERIOD.
- enable_timer low for a single cycle is a full clear. There is no resume.
- Asynchronous reset mid-frame forces all outputs to 0 immediately. After reset release, timing restarts only from edge 1 of the next enabled interval.
- Implicit states: IDLE (enable low), COUNTING, DONE. A separate state register is not required; the states are decoded from enable_timer and bit_index.

Decomposition:
- Package uart_rx_pkg holds:
  - constants CLKS_PER_BIT, FIRST_PERIOD and DATA_BITS, used as parameter defaults by rx_timer and the shift register;
  - a function that returns bit_index width.
- One sub-module, flex_counter, instantiated twice: once for clk_cnt and once for bit_index.
- flex_counter interface:
  - parameter NUM_CNT_BITS;
  - inputs clear, count_enable, rollover_val;
  - outputs count_out, rollover_flag;
  - asynchronous active-low reset;
  - synchronous clear has priority over counting.

Test Plan:
1. Assert n_rst low with enable_timer=1 -> shift_strobe=0, packet_done=0, bit_index=0 throughout reset.
2. Defaults, enable_timer held high 100 cycles -> single-cycle strobes at edges 12, 22, ..., 92 (9 total); bit_index 1..9; packet_done=1 from edge 92; no strobe at edges 93-100.
3. After test 2, drop enable_timer for 1 cycle then re-raise -> packet_done=0 and bit_index=0 one edge after the drop; next strobe 12 edges after re-enable.
4. Abort: enable_timer high for edges 1-40, then low -> strobes at 12, 22, 32 only; edge 41 shows bit_index=0; packet_done never asserts.
5. Pulse n_rst low between edges 50 and 51 with enable high -> outputs 0 asynchronously; after release, first strobe at the 12th enabled edge.
6. CLKS_PER_BIT=4, FIRST_PERIOD=6, DATA_BITS=5 -> strobes at edges 6, 10, 14, 18, 22, 26; packet_done rises at edge 26.
